lsu_io_responder: RTL

Memory-mapped peripheral responder on the load/store unit's I/O side. It serves the two peripheral regions that the LSU address select marks with codes 2'b01 (output peripherals at 0x1C00–0x1C0F) and 2'b00 (input peripherals at 0x1E00–0x1E07). It holds the output registers (red LEDs, 7-segment digits, LCD), synchronizes the switch and button inputs, and captures button-press events. It answers each LSU request with a one-cycle-latency valid/ready response.

---
 rtl/lsu_pkg.sv | 44 ++++
 rtl/io_input_sync.sv | 35 +++
 rtl/lsu_io_responder.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// Shared LSU definitions: region select codes, I/O word addresses, responder
// FSM states and a byte-lane merge helper.
package lsu_pkg;

  localparam logic [1:0] SEL_IN     = 2'b00;
  localparam logic [1:0] SEL_OUT    = 2'b01;
  localparam logic [1:0] SEL_MEM_LO = 2'b10;
  localparam logic [1:0] SEL_MEM_HI = 2'b11;

  // Word addresses, i.e. byte address [12:2].
  localparam logic [10:0] ADDR_LEDR = 11'h700;  // 0x1C00
  localparam logic [10:0] ADDR_HEX  = 11'h702;  // 0x1C08
  localparam logic [10:0] ADDR_LCD  = 11'h703;  // 0x1C0C
  localparam logic [10:0] ADDR_SW   = 11'h780;  // 0x1E00
  localparam logic [10:0] ADDR_BTN  = 11'h781;  // 0x1E04

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } state_e;

  // Classifies a word address; anything outside the two I/O windows belongs
  // to the memory side and is not served by the I/O responder.
  function automatic logic [1:0] io_region(input logic [10:0] word);
    logic [1:0] sel;
    if (word[10:2] == ADDR_LEDR[10:2])
      sel = SEL_OUT;
    else if (word[10:1] == ADDR_SW[10:1])
      sel = SEL_IN;
    else
      sel = SEL_MEM_LO;
    return sel;
  endfunction

  function automatic logic [31:0] merge_bytes(input logic [31:0] cur,
                                              input logic [31:0] wdata,
                                              input logic [3:0]  bmask);
    logic [31:0] res;
    for (int b = 0; b < 4; b++)
      res[8*b +: 8] = bmask[b] ? wdata[8*b +: 8] : cur[8*b +: 8];
    return res;
  endfunction

endpackage

// File: rtl/io_input_sync.sv
// Per-bit 2-flop synchronizer with a third delayed flop for rising-edge
// detection on the synchronized level.
module io_input_sync #(
  parameter int WIDTH = 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] level,
  output logic [WIDTH-1:0] rise
);

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      logic s1_reg, s2_reg, s3_reg;

      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          s1_reg <= 1'b0;
          s2_reg <= 1'b0;
          s3_reg <= 1'b0;
        end else begin
          s1_reg <= din[gi];
          s2_reg <= s1_reg;
          s3_reg <= s2_reg;
        end
      end

      assign level[gi] = s2_reg;
      assign rise[gi]  = s2_reg & ~s3_reg;
    end
  endgenerate

endmodule

// File: rtl/lsu_io_responder.sv
// LSU I/O responder: output registers (LEDR/HEX/LCD), synchronized switch and
// button inputs with sticky press events, one-cycle valid/ready response.
module lsu_io_responder
  import lsu_pkg::*;
#(
  parameter int NUM_SW  = 18,
  parameter int NUM_BTN = 4
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_req_valid,
  output logic               o_req_ready,
  input  logic               i_req_we,
  input  logic [12:0]        i_req_addr,
  input  logic [31:0]        i_req_wdata,
  input  logic [3:0]         i_req_bmask,
  output logic               o_rsp_valid,
  input  logic               i_rsp_ready,
  output logic [31:0]        o_rsp_rdata,
  output logic               o_rsp_err,
  input  logic [NUM_SW-1:0]  i_sw,
  input  logic [NUM_BTN-1:0] i_btn,
  output logic [31:0]        o_ledr,
  output logic [31:0]        o_hex,
  output logic [31:0]        o_lcd
);

  state_e state_reg, state_next;

  logic [31:0] ledr_reg, ledr_next;
  logic [31:0] hex_reg, hex_next;
  logic [31:0] lcd_reg, lcd_next;
  logic [31:0] rdata_reg, rdata_next;
  logic        err_reg, err_next;

  logic [NUM_BTN-1:0] sticky_reg, sticky_next;
  logic [NUM_BTN-1:0] clr_mask;

  logic [NUM_SW-1:0]  sw_level;
  logic [NUM_SW-1:0]  sw_rise_unused;
  logic [NUM_BTN-1:0] btn_level;
  logic [NUM_BTN-1:0] btn_rise;

  logic [10:0] word;
  logic [1:0]  region;
  logic [1:0]  addr_lsb_unused;
  logic        accept;

  io_input_sync #(.WIDTH(NUM_SW)) u_sw_sync (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .din     (i_sw),
    .level   (sw_level),
    .rise    (sw_rise_unused)
  );

  io_input_sync #(.WIDTH(NUM_BTN)) u_btn_sync (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .din     (i_btn),
    .level   (btn_level),
    .rise    (btn_rise)
  );

  assign word            = i_req_addr[12:2];
  assign addr_lsb_unused = i_req_addr[1:0];
  assign region          = io_region(word);
  assign accept          = (state_reg == ST_IDLE) && i_req_valid;

  // Decode of the presented request; only committed when it is accepted.
  always_comb begin
    ledr_next  = ledr_reg;
    hex_next   = hex_reg;
    lcd_next   = lcd_reg;
    rdata_next = '0;
    err_next   = 1'b1;
    clr_mask   = '0;
    case (region)
      SEL_OUT: begin
        case (word)
          ADDR_LEDR: begin
            err_next = 1'b0;
            if (i_req_we) ledr_next = merge_bytes(ledr_reg, i_req_wdata, i_req_bmask);
            else          rdata_next = ledr_reg;
          end
          ADDR_HEX: begin
            err_next = 1'b0;
            if (i_req_we) hex_next = merge_bytes(hex_reg, i_req_wdata, i_req_bmask);
            else          rdata_next = hex_reg;
          end
          ADDR_LCD: begin
            err_next = 1'b0;
            if (i_req_we) lcd_next = merge_bytes(lcd_reg, i_req_wdata, i_req_bmask);
            else          rdata_next = lcd_reg;
          end
          default: ;
        endcase
      end
      SEL_IN: begin
        // Inputs are read-only: a store keeps the error default and does nothing.
        if (!i_req_we) begin
          err_next = 1'b0;
          if (word == ADDR_SW) begin
            rdata_next[NUM_SW-1:0] = sw_level;
          end else begin
            rdata_next[NUM_BTN-1:0]  = sticky_reg;
            rdata_next[8 +: NUM_BTN] = btn_level;
            clr_mask                 = sticky_reg;
          end
        end
      end
      default: ;
    endcase
  end

  // A fresh edge in the clearing cycle survives because the set term is OR-ed last.
  assign sticky_next = (sticky_reg & ~(accept ? clr_mask : {NUM_BTN{1'b0}})) | btn_rise;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (i_req_valid) state_next = ST_RESP;
      ST_RESP: if (i_rsp_ready) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg  <= ST_IDLE;
      ledr_reg   <= '0;
      hex_reg    <= '0;
      lcd_reg    <= '0;
      rdata_reg  <= '0;
      err_reg    <= 1'b0;
      sticky_reg <= '0;
    end else begin
      state_reg  <= state_next;
      sticky_reg <= sticky_next;
      if (accept) begin
        ledr_reg  <= ledr_next;
        hex_reg   <= hex_next;
        lcd_reg   <= lcd_next;
        rdata_reg <= rdata_next;
        err_reg   <= err_next;
      end
    end
  end

  assign o_req_ready = (state_reg == ST_IDLE);
  assign o_rsp_valid = (state_reg == ST_RESP);
  assign o_rsp_rdata = rdata_reg;
  assign o_rsp_err   = err_reg;
  assign o_ledr      = ledr_reg;
  assign o_hex       = hex_reg;
  assign o_lcd       = lcd_reg;

endmodule
